// File: rtl/ram_scan_pkg.sv
// Shared sizes, read-mode encoding and default timing constants for the RAM scan display path.
package ram_scan_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int SCAN_DIV_DEFAULT   = 50_000_000;
    localparam int DEB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/ram_scan_btn_sync.sv
// Two-flop synchronizer with rising-edge pulse for a raw board input.
// With RAM_SCAN_DEBOUNCE_EN defined, instances with USE_DEB=1 also debounce the synchronized level.
module btn_sync
    import ram_scan_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter bit USE_DEB    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

`ifdef RAM_SCAN_DEBOUNCE_EN
    localparam bit DEB_ON = USE_DEB;
`else
    localparam bit DEB_ON = 1'b0 & USE_DEB;
`endif

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;
    logic acc;

    always_comb begin
        s1_d   = raw;
        s2_d   = s1_q;
        prev_d = acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    generate
        if (DEB_ON) begin : g_deb
            localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

            logic             deb_q, deb_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // The counter only advances while the input disagrees with the accepted level.
            always_comb begin
                deb_d = deb_q;
                cnt_d = '0;
                if (s2_q != deb_q) begin
                    if (cnt_q == CNT_LAST) begin
                        deb_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    deb_q <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    deb_q <= deb_d;
                    cnt_q <= cnt_d;
                end
            end

            assign acc = deb_q;
        end else begin : g_nodeb
            assign acc = s2_q;
        end
    endgenerate

    assign level = prev_q;
    assign rise  = acc & ~prev_q;

endmodule

// File: rtl/ram_scan.sv
// 16x8 register-file RAM with button write port and manual/scan registered read port.
// RAM_SCAN_DEBOUNCE_EN adds a DEB_CYCLES debounce on the write button.
module ram_scan
    import ram_scan_pkg::*;
#(
    parameter int SCAN_DIV   = SCAN_DIV_DEFAULT,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_btn,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr_sw,
    input  logic [DATA_W-1:0] din_sw,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] addr_out,
    output logic              wr_ack
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // Cycles after reset before the synchronized button level reflects the real button.
`ifdef RAM_SCAN_DEBOUNCE_EN
    localparam int SETTLE = DEB_CYCLES + 4;
`else
    localparam int SETTLE = 4;
`endif
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE);

    logic wr_level, wr_rise;
    logic mode_level, mode_rise;

    btn_sync #(.DEB_CYCLES(DEB_CYCLES), .USE_DEB(1'b1)) u_wr_sync (
        .clk   (clk),
        .rst   (rst),
        .raw   (wr_btn),
        .level (wr_level),
        .rise  (wr_rise)
    );

    btn_sync #(.DEB_CYCLES(DEB_CYCLES), .USE_DEB(1'b0)) u_mode_sync (
        .clk   (clk),
        .rst   (rst),
        .raw   (mode),
        .level (mode_level),
        .rise  (mode_rise)
    );

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic              wr_ack_q, wr_ack_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [ADDR_W-1:0] scan_q, scan_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic              armed_q, armed_d;

    mode_e             rd_mode;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;

    always_comb begin
        rd_mode = mode_level ? MODE_SCAN : MODE_MANUAL;
        rd_addr = (rd_mode == MODE_SCAN) ? scan_q : addr_sw;

        // A button already held when reset releases must be let go before it can write.
        settle_d = (settle_q == SET_LAST) ? settle_q : settle_q + 1'b1;
        armed_d  = armed_q | ((settle_q == SET_LAST) & ~wr_level);
        wr_en    = wr_rise & armed_q;

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[addr_sw] = din_sw;
        end

        dout_d     = (wr_en && (addr_sw == rd_addr)) ? din_sw : mem_q[rd_addr];
        addr_out_d = rd_addr;
        wr_ack_d   = wr_en;

        div_d  = div_q;
        scan_d = scan_q;
        if (mode_rise) begin
            div_d  = '0;
            scan_d = '0;
        end else if (rd_mode == MODE_SCAN) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                scan_d = scan_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q     <= '0;
            addr_out_q <= '0;
            wr_ack_q   <= 1'b0;
            div_q      <= '0;
            scan_q     <= '0;
            settle_q   <= '0;
            armed_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            dout_q     <= dout_d;
            addr_out_q <= addr_out_d;
            wr_ack_q   <= wr_ack_d;
            div_q      <= div_d;
            scan_q     <= scan_d;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
        end
    end

    assign dout     = dout_q;
    assign addr_out = addr_out_q;
    assign wr_ack   = wr_ack_q;

endmodule

// File: tb/tb_ram_scan.sv
// Self-checking bench for ram_scan: table-driven writes/reads, random writes against a memory model,
// held-button, mid-cycle reset, scan walk and write/read collision; debounce cases under RAM_SCAN_DEBOUNCE_EN.
module tb_ram_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
`ifdef RAM_SCAN_DEBOUNCE_EN
    localparam int DLY = DEB;
`else
    localparam int DLY = 0;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       wr_btn  = 1'b0;
    logic       mode    = 1'b0;
    logic [3:0] addr_sw = 4'h0;
    logic [7:0] din_sw  = 8'h00;
    logic [7:0] dout;
    logic [3:0] addr_out;
    logic       wr_ack;

    ram_scan #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_btn   (wr_btn),
        .mode     (mode),
        .addr_sw  (addr_sw),
        .din_sw   (din_sw),
        .dout     (dout),
        .addr_out (addr_out),
        .wr_ack   (wr_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [7:0] model [16];

    typedef struct {
        logic [3:0] addr;
        logic [7:0] din;
        int         hold;
        logic [7:0] exp_dout;
    } vec_t;
    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Button is driven high ahead of the next edge; with hold h it is seen high for h edges.
    task automatic press(input logic [3:0] a, input logic [7:0] d, input int hold,
                         input int chg_at, input logic [7:0] chg_val);
        int acks;
        int first;
        acks    = 0;
        first   = -1;
        addr_sw = a;
        din_sw  = d;
        wr_btn  = 1'b1;
        for (int k = 1; k <= hold + DLY + 10; k++) begin
            tick();
            if (wr_ack) begin
                acks++;
                if (first < 0) first = k;
            end
            if (k == 4 + DLY) begin
                chk("write_dout", dout, d);
                chk("write_addr_out", addr_out, a);
            end
            if (k == chg_at) din_sw = chg_val;
            if (k == hold) wr_btn = 1'b0;
        end
        chk("ack_count", acks, 1);
        chk("ack_cycle", first, 3 + DLY);
        model[a] = d;
        $display("write addr=%0d data=0x%02h hold=%0d acks=%0d ack_cycle=%0d", a, d, hold, acks, first);
    endtask

    task automatic read_chk(input logic [3:0] a, input string name);
        addr_sw = a;
        tick();
        chk({name, "_addr"}, addr_out, a);
        chk({name, "_dout"}, dout, model[a]);
        $display("read  addr=%0d dout=0x%02h expected=0x%02h", a, dout, model[a]);
    endtask

    task automatic scan_run(input bit collide);
        int j;
        int ea;
        int k0;
        k0   = 14 - DLY;
        mode = 1'b0;
        repeat (6) tick();
        mode = 1'b1;
        for (int k = 1; k <= 4 + 16 * SCAN_DIV; k++) begin
            if (collide && k == k0) begin
                addr_sw = 4'h3;
                din_sw  = 8'h3C;
                wr_btn  = 1'b1;
            end
            if (collide && k == k0 + DLY + 2) wr_btn = 1'b0;
            tick();
            if (collide && k == 16) begin
                model[3] = 8'h3C;
                chk("collide_ack", wr_ack, 1);
            end
            if (k >= 4) begin
                j  = k - 4;
                ea = (j / SCAN_DIV) % 16;
                chk(collide ? "collide_addr" : "scan_addr", addr_out, ea);
                chk(collide ? "collide_dout" : "scan_dout", dout, model[ea]);
            end
        end
        $display("scan run collide=%0d ended at addr_out=%0d dout=0x%02h", collide, addr_out, dout);
        mode   = 1'b0;
        wr_btn = 1'b0;
        repeat (DLY + 10) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        logic [3:0] ra;

        vecs[0] = '{4'h5, 8'hA7, 3, 8'hA7};
        vecs[1] = '{4'h0, 8'h3C, 2, 8'h3C};
        vecs[2] = '{4'hF, 8'hFF, 5, 8'hFF};
        vecs[3] = '{4'hA, 8'h01, 2, 8'h01};
        vecs[4] = '{4'h3, 8'h80, 4, 8'h80};
        vecs[5] = '{4'hC, 8'h5E, 2, 8'h5E};
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_dout", dout, 0);
        chk("reset_addr_out", addr_out, 0);
        chk("reset_wr_ack", wr_ack, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (DLY + 12) tick();

        for (int i = 0; i < 16; i++) read_chk(i[3:0], "reset_read");

        for (int i = 0; i < 6; i++) press(vecs[i].addr, vecs[i].din, vecs[i].hold + DLY, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            addr_sw = vecs[i].addr;
            tick();
            chk("table_dout", dout, vecs[i].exp_dout);
            chk("table_addr", addr_out, vecs[i].addr);
            $display("table addr=%0d dout=0x%02h expected=0x%02h", vecs[i].addr, dout, vecs[i].exp_dout);
        end

        press(4'h7, 8'h11, 100, 50, 8'h22);
        read_chk(4'h7, "held_read");

        repeat (10) begin
            press(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                  int'($urandom_range(DLY + 2, DLY + 12)), 0, 8'h00);
        end
        repeat (16) begin
            ra = 4'($urandom_range(0, 15));
            read_chk(ra, "rand_read");
        end

        // Reset lands while wr_ack is high; the button stays held through reset release.
        addr_sw = 4'h9;
        din_sw  = 8'h5A;
        wr_btn  = 1'b1;
        repeat (3 + DLY) tick();
        chk("pre_reset_ack", wr_ack, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midcycle_reset_dout", dout, 0);
        chk("midcycle_reset_addr_out", addr_out, 0);
        chk("midcycle_reset_wr_ack", wr_ack, 0);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        @(negedge clk);
        rst  = 1'b0;
        acks = 0;
        repeat (30) begin
            tick();
            if (wr_ack) acks++;
        end
        chk("held_through_reset_acks", acks, 0);
        $display("held-through-reset acks=%0d", acks);
        wr_btn = 1'b0;
        repeat (DLY + 8) tick();
        for (int i = 0; i < 16; i++) read_chk(i[3:0], "post_reset_read");
        press(4'h9, 8'h5A, DLY + 2, 0, 8'h00);

        for (int i = 0; i < 16; i++) press(i[3:0], 8'(i * 8'h11), DLY + 2, 0, 8'h00);
        scan_run(1'b0);
        scan_run(1'b1);

`ifdef RAM_SCAN_DEBOUNCE_EN
        addr_sw = 4'h2;
        din_sw  = 8'hEE;
        wr_btn  = 1'b1;
        repeat (5) tick();
        wr_btn = 1'b0;
        acks   = 0;
        repeat (30) begin
            tick();
            if (wr_ack) acks++;
        end
        chk("glitch_acks", acks, 0);
        $display("glitch press acks=%0d", acks);
        read_chk(4'h2, "glitch_read");
        press(4'h2, 8'hD4, 20, 0, 8'h00);
        read_chk(4'h2, "debounce_read");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
